func_unit_r: RTL and testbench

//  Integer functional unit fed by the R-type reservation station. Latches operands and opcode on dispatch,

---
 rtl/func_unit_r_pkg.sv | 51 +++++
 rtl/func_unit_r_iter_unit.sv | 96 +++++++++
 rtl/func_unit_r.sv | 165 ++++++++++++++++
 tb/tb_func_unit_r.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/func_unit_r_pkg.sv
// Shared definitions for the R-type functional unit: opcodes, FSM states, iterative-unit modes.
// Optional feature macro: FU_MUL_EN (enables the 16-iteration shift-add multiplier).
package func_unit_r_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TAG_W_DEF  = 3;
  localparam int RDST_W_DEF = 3;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] MUL_ITERS = 5'd16;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_MUL = 3'b111
  } fu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_EXEC     = 2'b01,
    ST_WAIT_CDB = 2'b10
  } fu_state_e;

  typedef enum logic [1:0] {
    IT_SLL = 2'b00,
    IT_SRL = 2'b01,
    IT_MUL = 2'b10
  } iter_mode_e;

  // Ops that run through the iterative datapath instead of the single-cycle ALU.
  function automatic logic is_iter_op(fu_op_e op);
`ifdef FU_MUL_EN
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_MUL);
`else
    return (op == OP_SLL) || (op == OP_SRL);
`endif
  endfunction

  function automatic iter_mode_e to_iter_mode(fu_op_e op);
    case (op)
      OP_SLL:  return IT_SLL;
      OP_SRL:  return IT_SRL;
      default: return IT_MUL;
    endcase
  endfunction

endpackage

// File: rtl/func_unit_r_iter_unit.sv
// Iterative datapath: one-bit-per-cycle shifter and (with FU_MUL_EN) a shift-add multiplier.
// load captures operands, step advances one iteration, last flags the final step.
module fu_iter_unit
  import func_unit_r_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  iter_mode_e        mode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              last,
  output logic [DATA_W-1:0] result
);

  iter_mode_e        mode_q, mode_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_step;

`ifdef FU_MUL_EN
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
`else
  logic unused_b;
  assign unused_b = ^b[DATA_W-1:4];
`endif

  always_comb begin
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    acc_step = acc_q;
`ifdef FU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    // A zero shift amount leaves the operand untouched for its single EXEC cycle.
    case (mode_q)
      IT_SLL: if (cnt_q != '0) acc_step = acc_q << 1;
      IT_SRL: if (cnt_q != '0) acc_step = acc_q >> 1;
`ifdef FU_MUL_EN
      IT_MUL: if (mplier_q[0]) acc_step = acc_q + mcand_q;
`endif
      default: acc_step = acc_q;
    endcase

    if (load) begin
      mode_d = mode;
      acc_d  = a;
      cnt_d  = {1'b0, b[3:0]};
`ifdef FU_MUL_EN
      mcand_d  = a;
      mplier_d = b;
      if (mode == IT_MUL) begin
        acc_d = '0;
        cnt_d = MUL_ITERS;
      end
`endif
    end else if (step) begin
      acc_d = acc_step;
      cnt_d = (cnt_q != '0) ? cnt_q - 5'd1 : '0;
`ifdef FU_MUL_EN
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
`endif
    end
  end

  assign last   = (cnt_q <= 5'd1);
  assign result = acc_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q <= IT_SLL;
      acc_q  <= '0;
      cnt_q  <= '0;
`ifdef FU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      mode_q <= mode_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
`ifdef FU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

endmodule

// File: rtl/func_unit_r.sv
// R-type integer functional unit: dispatch latch, op-dependent execute, CDB request/grant, Done pulse.
// Optional feature macro: FU_MUL_EN (iterative MUL; otherwise MUL yields zero in one cycle).
// Handshake: dispatch happens on an edge with Start && Ready; the result is broadcast on the edge
// where Cdb_grant is high while Cdb_req is high, and Cdb_* outputs stay frozen until that edge.
module func_unit_r
  import func_unit_r_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int RDST_W = RDST_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [2:0]        Ufop,
  input  logic [DATA_W-1:0] Vj,
  input  logic [DATA_W-1:0] Vk,
  input  logic [TAG_W-1:0]  Tag_in,
  input  logic [RDST_W-1:0] R_target_in,
  output logic              Ready,
  output logic              Busy,
  output logic              Cdb_req,
  input  logic              Cdb_grant,
  output logic [TAG_W-1:0]  Cdb_tag,
  output logic [DATA_W-1:0] Cdb_value,
  output logic [RDST_W-1:0] Cdb_rtarget,
  output logic              Done,
  output logic [1:0]        dbg_state
);

  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  fu_state_e         state_q, state_d;
  fu_op_e            op_q, op_d;
  logic [DATA_W-1:0] vj_q, vj_d, vk_q, vk_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [RDST_W-1:0] rt_q, rt_d;
  logic              cdb_req_q, cdb_req_d;
  logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0] cdb_value_q, cdb_value_d;
  logic [RDST_W-1:0] cdb_rtarget_q, cdb_rtarget_d;
  logic              done_q, done_d;

  fu_op_e            op_in;
  logic              accept;
  logic              iter_load, iter_step, iter_last;
  logic [DATA_W-1:0] iter_result;
  logic [DATA_W-1:0] alu_result;
  logic              exec_last;
  logic [DATA_W-1:0] exec_result;

  assign op_in     = fu_op_e'(Ufop);
  assign accept    = Start && (state_q == ST_IDLE);
  assign iter_load = accept && is_iter_op(op_in);
  assign iter_step = (state_q == ST_EXEC) && is_iter_op(op_q);

  fu_iter_unit #(.DATA_W(DATA_W)) u_iter (
    .clk    (Clock),
    .rst_n  (Reset),
    .load   (iter_load),
    .step   (iter_step),
    .mode   (to_iter_mode(op_in)),
    .a      (Vj),
    .b      (Vk),
    .last   (iter_last),
    .result (iter_result)
  );

  // Single-cycle ops; MUL lands in default when the multiplier is not built.
  always_comb begin
    alu_result = '0;
    case (op_q)
      OP_ADD:  alu_result = vj_q + vk_q;
      OP_SUB:  alu_result = vj_q - vk_q;
      OP_AND:  alu_result = vj_q & vk_q;
      OP_OR:   alu_result = vj_q | vk_q;
      OP_SLT:  alu_result = ($signed(vj_q) < $signed(vk_q)) ? ONE : '0;
      default: alu_result = '0;
    endcase
  end

  assign exec_last   = is_iter_op(op_q) ? iter_last : 1'b1;
  assign exec_result = is_iter_op(op_q) ? iter_result : alu_result;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    vj_d          = vj_q;
    vk_d          = vk_q;
    tag_d         = tag_q;
    rt_d          = rt_q;
    cdb_req_d     = cdb_req_q;
    cdb_tag_d     = cdb_tag_q;
    cdb_value_d   = cdb_value_q;
    cdb_rtarget_d = cdb_rtarget_q;
    done_d        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = op_in;
          vj_d    = Vj;
          vk_d    = Vk;
          tag_d   = Tag_in;
          rt_d    = R_target_in;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_last) begin
          cdb_req_d     = 1'b1;
          cdb_value_d   = exec_result;
          cdb_tag_d     = tag_q;
          cdb_rtarget_d = rt_q;
          state_d       = ST_WAIT_CDB;
        end
      end
      ST_WAIT_CDB: begin
        if (Cdb_grant && cdb_req_q) begin
          cdb_req_d = 1'b0;
          done_d    = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q       <= ST_IDLE;
      op_q          <= OP_ADD;
      vj_q          <= '0;
      vk_q          <= '0;
      tag_q         <= '0;
      rt_q          <= '0;
      cdb_req_q     <= 1'b0;
      cdb_tag_q     <= '0;
      cdb_value_q   <= '0;
      cdb_rtarget_q <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      vj_q          <= vj_d;
      vk_q          <= vk_d;
      tag_q         <= tag_d;
      rt_q          <= rt_d;
      cdb_req_q     <= cdb_req_d;
      cdb_tag_q     <= cdb_tag_d;
      cdb_value_q   <= cdb_value_d;
      cdb_rtarget_q <= cdb_rtarget_d;
      done_q        <= done_d;
    end
  end

  assign Ready       = (state_q == ST_IDLE);
  assign Busy        = (state_q != ST_IDLE);
  assign Cdb_req     = cdb_req_q;
  assign Cdb_tag     = cdb_tag_q;
  assign Cdb_value   = cdb_value_q;
  assign Cdb_rtarget = cdb_rtarget_q;
  assign Done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_func_unit_r.sv
// Directed bench for func_unit_r: scoreboard of expected CDB broadcasts, latency and hold checks.
module tb_func_unit_r;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  ufop;
  logic [15:0] vj, vk;
  logic [2:0]  tag_in, rt_in;
  logic        ready, busy, cdb_req, cdb_grant, done;
  logic [2:0]  cdb_tag, cdb_rtarget;
  logic [15:0] cdb_value;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic [21:0] exp_q[$];

  always #5 clk = ~clk;

  func_unit_r dut (
    .Clock(clk), .Reset(rst_n), .Start(start), .Ufop(ufop), .Vj(vj), .Vk(vk),
    .Tag_in(tag_in), .R_target_in(rt_in), .Ready(ready), .Busy(busy),
    .Cdb_req(cdb_req), .Cdb_grant(cdb_grant), .Cdb_tag(cdb_tag),
    .Cdb_value(cdb_value), .Cdb_rtarget(cdb_rtarget), .Done(done),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(a) * 32'(b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
      3'd5: return a << b[3:0];
      3'd6: return a >> b[3:0];
`ifdef FU_MUL_EN
      default: return p[15:0];
`else
      default: return 16'h0000;
`endif
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] op, input logic [15:0] b);
    if (op == 3'd5 || op == 3'd6) return (b[3:0] == 4'd0) ? 1 : int'(b[3:0]);
`ifdef FU_MUL_EN
    if (op == 3'd7) return 16;
`endif
    return 1;
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] tg, input logic [2:0] rt, input int gdly);
    int lat;
    logic [21:0] hold, exp;
    @(negedge clk);
    start = 1'b1; ufop = op; vj = a; vk = b; tag_in = tg; rt_in = rt; cdb_grant = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back({tg, rt, model(op, a, b)});
    chk("accept_ready", ready, 0);
    chk("accept_busy", busy, 1);
    chk("single_done", done, 0);
    lat = 0;
    while (cdb_req !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, exp_latency(op, b));
    hold = {cdb_tag, cdb_rtarget, cdb_value};
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      start = 1'b1; ufop = 3'($urandom_range(0, 7)); vj = 16'($urandom); vk = 16'($urandom);
      @(posedge clk); #1;
      chk("hold_req", cdb_req, 1);
      chk("hold_out", {10'd0, cdb_tag, cdb_rtarget, cdb_value}, {10'd0, hold});
      chk("hold_ready", ready, 0);
      chk("hold_done", done, 0);
    end
    @(negedge clk);
    start = 1'b0; cdb_grant = 1'b1;
    chk("sb_nonempty", exp_q.size(), 1);
    exp = exp_q.pop_front();
    chk("cdb_out", {10'd0, cdb_tag, cdb_rtarget, cdb_value}, {10'd0, exp});
    @(posedge clk); #1;
    cdb_grant = 1'b0;
    chk("done_pulse", done, 1);
    chk("req_drop", cdb_req, 0);
    chk("ready_back", ready, 1);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    logic [21:0] exp;
    int seen;
    rst_n = 1'b0; start = 1'b0; ufop = '0; vj = '0; vk = '0; tag_in = '0; rt_in = '0; cdb_grant = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", cdb_req, 0);
    chk("rst_done", done, 0);
    chk("rst_outs", {cdb_tag, cdb_rtarget, cdb_value}, 0);
    chk("rst_state", dbg_state, 0);

    // ADD with grant tied high: grant ignored during EXEC, broadcast after 2 edges.
    @(negedge clk);
    cdb_grant = 1'b1; start = 1'b1; ufop = 3'd0; vj = 16'd5; vk = 16'd7; tag_in = 3'd2; rt_in = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back({3'd2, 3'd1, 16'h000C});
    chk("add_exec_state", dbg_state, 1);
    chk("add_req_early", cdb_req, 0);
    @(posedge clk); #1;
    chk("add_req", cdb_req, 1);
    exp = exp_q.pop_front();
    chk("add_out", {10'd0, cdb_tag, cdb_rtarget, cdb_value}, {10'd0, exp});
    @(posedge clk); #1;
    chk("add_done", done, 1);
    chk("add_req_drop", cdb_req, 0);
    @(posedge clk); #1;
    chk("add_done_once", done, 0);
    chk("idle_grant_req", cdb_req, 0);
    @(negedge clk); cdb_grant = 1'b0;

    run_op(3'd1, 16'd3, 16'd5, 3'd3, 3'd4, 0);          // SUB -> FFFE
    run_op(3'd4, 16'hFFFF, 16'd1, 3'd4, 3'd5, 0);       // SLT signed -> 1
    run_op(3'd4, 16'd1, 16'hFFFF, 3'd1, 3'd0, 0);       // SLT signed -> 0
    run_op(3'd5, 16'd1, 16'd4, 3'd5, 3'd2, 0);          // SLL 4 cycles -> 0010
    run_op(3'd5, 16'h1234, 16'd0, 3'd6, 3'd3, 0);       // SLL by 0 -> unchanged
    run_op(3'd6, 16'h8001, 16'h0013, 3'd7, 3'd6, 0);    // SRL 3 logical -> 1000
    run_op(3'd2, 16'hF0F0, 16'h3C3C, 3'd0, 3'd7, 3);    // AND, grant delayed
    run_op(3'd3, 16'hF000, 16'h000F, 3'd1, 3'd1, 3);    // OR, grant delayed
    run_op(3'd0, 16'hFFFF, 16'd2, 3'd2, 3'd2, 0);       // ADD wraps
    run_op(3'd7, 16'd300, 16'd300, 3'd3, 3'd5, 1);      // MUL
    run_op(3'd6, 16'hFFFF, 16'h000F, 3'd4, 3'd4, 0);    // SRL 15

    for (int i = 0; i < 6; i++)
      run_op(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 2));

    // Reset in the middle of a MUL aborts it with no broadcast and no Done.
    @(negedge clk);
    start = 1'b1; ufop = 3'd7; vj = 16'd300; vk = 16'd300; tag_in = 3'd6; rt_in = 3'd6;
    @(posedge clk); #1;
    start = 1'b0;
    chk("mul_busy", busy, 1);
`ifdef FU_MUL_EN
    repeat (5) @(posedge clk);
`endif
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_req", cdb_req, 0);
    chk("abort_value", cdb_value, 0);
    @(negedge clk); rst_n = 1'b1; cdb_grant = 1'b1;
    seen = 0;
    repeat (24) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || cdb_req !== 1'b0) seen++;
    end
    chk("abort_quiet", seen, 0);
    @(negedge clk); cdb_grant = 1'b0;

    run_op(3'd0, 16'h0100, 16'h0023, 3'd5, 3'd7, 1);    // recovery after abort
    @(posedge clk); #1;
    chk("final_done_once", done, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
